alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of reservation-station entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TAG_BITS, default 6, meaning the physical destination/operand tag width and matching writeback_packet_t.dest_reg.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 flush  input  1  mispredict flush; synchronous, active-high.
REQ-006 dispatch_valid  input  1  dispatch offers dispatch_packet this cycle.
REQ-007 dispatch_rdy  output  1  at least one entry is free.
REQ-008 dispatch_packet  input  $bits(instruction_t)  instruction with four operand slots (src_0_a, src_0_b, src_1_a, src_1_b), each with data, tag and rdy fields.
REQ-009 cdb_packet  input  $bits(writeback_packet_t)  CDB broadcast: is_valid, dest_reg (tag), result.
REQ-010 alu_rdy  input  1  ALU accepts a packet this cycle.
REQ-011 alu_packet  output  $bits(instruction_t)  issued instruction; is_valid=0 when nothing issues.
REQ-012 rs_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-013 Each entry SHALL hold: valid bit, instruction_t payload, per-slot rdy bit and tag.
REQ-014 Dispatch accept SHALL occur when dispatch_valid && dispatch_rdy && !flush; the packet is written into the lowest-index free entry at the next edge.
REQ-015 dispatch_rdy SHALL be computed from registered occupancy only (rs_count < DEPTH); a same-cycle issue SHALL NOT create dispatch credit.
REQ-016 Wakeup: when cdb_packet.is_valid and an occupied entry's not-ready slot tag equals cdb_packet.dest_reg, that slot SHALL capture result and set rdy at the next edge; all matching slots in all entries update in parallel.
REQ-017 Dispatch bypass: a dispatched slot with rdy=0 whose tag matches a same-cycle valid CDB broadcast SHALL be written with rdy=1 and the CDB result.
REQ-018 An entry SHALL be eligible for issue only when valid and all four slot rdy bits are set in registered state; an entry woken this cycle issues no earlier than next cycle.
REQ-019 Select SHALL pick the lowest-index eligible entry; alu_packet SHALL present that entry's payload combinationally with is_valid=1, else all-zero.
REQ-020 Issue SHALL occur when alu_rdy=1 and an eligible entry exists; that entry's valid bit clears at the next edge; with alu_rdy=0 the same packet SHALL remain presented unchanged.
REQ-021 Simultaneous dispatch and issue SHALL both take effect; rs_count SHALL change by (+1 accept) + (-1 issue); a freed entry SHALL not be reused by the same-cycle dispatch.
REQ-022 Full (rs_count=DEPTH): dispatch_rdy=0, dispatch_valid ignored. Empty: alu_packet.is_valid=0.
REQ-023 flush SHALL clear all valid bits and rs_count to 0 at the next edge, overriding dispatch, wakeup and issue that cycle; alu_packet is still driven combinationally during the flush cycle.
REQ-024 CDB broadcasts with is_valid=0 SHALL have no effect; slots already rdy SHALL ignore matching tags.

Reset
REQ-025 While rst=0 all entry valid bits, rdy bits and rs_count SHALL be 0 immediately (asynchronously); dispatch_rdy=1 and alu_packet all-zero.
REQ-026 Reset asserted mid-operation SHALL discard all entries without issuing; first dispatch is accepted on the first edge after rst returns to 1.

Verification
REQ-027 Ready dispatch: dispatch ADD with all slots rdy, alu_rdy=1 -> alu_packet.is_valid=1 the next cycle, rs_count 1->0 one edge later.
REQ-028 Wakeup: dispatch with src_0_b tag 5 not ready; CDB dest_reg=5 result=0x1234 at cycle N -> issue at N+1 with src_0_b=0x1234.
REQ-029 Bypass: dispatch slot tag 7 not ready in the same cycle as CDB tag 7 result=0xDEAD -> entry eligible next cycle carrying 0xDEAD.
REQ-030 Full/backpressure: alu_rdy=0, dispatch DEPTH ready ops -> dispatch_rdy=0 at rs_count=8, alu_packet stable (entry 0); alu_rdy=1 -> entries issue in index order 0..7.
REQ-031 Simultaneous: full station, dispatch_valid=1 and issue same cycle -> dispatch not accepted, rs_count 8->7.
REQ-032 Flush/reset: 5 entries occupied, flush=1 with concurrent dispatch -> rs_count=0 next edge, nothing issues; repeat with rst=0 mid-cycle -> outputs cleared before the next edge.

Source files
------------

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - ALU reservation-station packet types and dispatch/CDB/issue interface
package alu_rs_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              rdy;
  } operand_t;

  typedef struct packed {
    logic             is_valid;
    logic [3:0]       opcode;
    logic [TAG_W-1:0] dest_reg;
    operand_t         src_0_a;
    operand_t         src_0_b;
    operand_t         src_1_a;
    operand_t         src_1_b;
  } instruction_t;

  typedef struct packed {
    logic              is_valid;
    logic [TAG_W-1:0]  dest_reg;
    logic [DATA_W-1:0] result;
  } writeback_packet_t;
endpackage

interface alu_rs_if #(parameter int DEPTH = 8) ();
  logic                            dispatch_valid;
  logic                            dispatch_rdy;
  alu_rs_pkg::instruction_t        dispatch_packet;
  alu_rs_pkg::writeback_packet_t   cdb_packet;
  logic                            alu_rdy;
  alu_rs_pkg::instruction_t        alu_packet;
  logic [$clog2(DEPTH):0]          rs_count;

  modport master (
    output dispatch_valid, dispatch_packet, cdb_packet, alu_rdy,
    input  dispatch_rdy, alu_packet, rs_count
  );

  modport slave (
    input  dispatch_valid, dispatch_packet, cdb_packet, alu_rdy,
    output dispatch_rdy, alu_packet, rs_count
  );
endinterface

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: dispatch with CDB bypass, parallel wakeup,
// lowest-index select/issue, flush and asynchronous active-low reset.
module alu_rs #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = alu_rs_pkg::TAG_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_rs_if.slave  rs
);
  import alu_rs_pkg::*;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic         valid_q   [DEPTH];
  logic         valid_d   [DEPTH];
  instruction_t payload_q [DEPTH];
  instruction_t payload_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  logic          issue_any, free_any, accept, issue;
  logic [IW-1:0] issue_idx, free_idx;
  instruction_t  sel_pkt, disp_pkt;

  // A not-ready slot captures a valid broadcast whose tag matches; ready slots keep their data.
  function automatic operand_t wake(input operand_t op, input writeback_packet_t cdb);
    operand_t r;
    r = op;
    if (cdb.is_valid && !op.rdy && (op.tag[TAG_BITS-1:0] == cdb.dest_reg[TAG_BITS-1:0])) begin
      r.data = cdb.result;
      r.rdy  = 1'b1;
    end
    return r;
  endfunction

  function automatic logic all_rdy(input instruction_t p);
    return p.src_0_a.rdy && p.src_0_b.rdy && p.src_1_a.rdy && p.src_1_b.rdy;
  endfunction

  // Select and free search both look only at registered state, so an entry freed by
  // this cycle's issue is never the target of this cycle's dispatch.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && all_rdy(payload_q[i])) begin
        issue_any = 1'b1;
        issue_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    sel_pkt = '0;
    if (issue_any) begin
      sel_pkt          = payload_q[issue_idx];
      sel_pkt.is_valid = 1'b1;
    end
  end

  assign rs.alu_packet   = sel_pkt;
  assign rs.dispatch_rdy = (count_q < CW'(DEPTH));
  assign rs.rs_count     = count_q;

  assign accept = rs.dispatch_valid && rs.dispatch_rdy && free_any && !flush;
  assign issue  = issue_any && rs.alu_rdy && !flush;

  always_comb begin
    disp_pkt          = rs.dispatch_packet;
    disp_pkt.is_valid = 1'b1;
    disp_pkt.src_0_a  = wake(rs.dispatch_packet.src_0_a, rs.cdb_packet);
    disp_pkt.src_0_b  = wake(rs.dispatch_packet.src_0_b, rs.cdb_packet);
    disp_pkt.src_1_a  = wake(rs.dispatch_packet.src_1_a, rs.cdb_packet);
    disp_pkt.src_1_b  = wake(rs.dispatch_packet.src_1_b, rs.cdb_packet);
  end

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    count_d   = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        payload_d[i].src_0_a = wake(payload_q[i].src_0_a, rs.cdb_packet);
        payload_d[i].src_0_b = wake(payload_q[i].src_0_b, rs.cdb_packet);
        payload_d[i].src_1_a = wake(payload_q[i].src_1_a, rs.cdb_packet);
        payload_d[i].src_1_b = wake(payload_q[i].src_1_b, rs.cdb_packet);
      end
    end
    if (issue) begin
      valid_d[issue_idx] = 1'b0;
    end
    if (accept) begin
      valid_d[free_idx]   = 1'b1;
      payload_d[free_idx] = disp_pkt;
    end
    count_d = count_q + CW'(accept) - CW'(issue);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        payload_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  instruction_t pkt;

  always #5 clk = ~clk;

  alu_rs_if #(.DEPTH(8)) bus ();

  alu_rs #(.DEPTH(8), .TAG_BITS(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .rs    (bus)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic operand_t op(input logic [31:0] d, input logic [5:0] t, input logic r);
    operand_t o;
    o.data = d;
    o.tag  = t;
    o.rdy  = r;
    return o;
  endfunction

  function automatic instruction_t rdy_inst(input logic [3:0] opc, input logic [31:0] d);
    instruction_t p;
    p.is_valid = 1'b1;
    p.opcode   = opc;
    p.dest_reg = 6'd1;
    p.src_0_a  = op(d, 6'd10, 1'b1);
    p.src_0_b  = op(d + 32'd1, 6'd11, 1'b1);
    p.src_1_a  = op(d + 32'd2, 6'd12, 1'b1);
    p.src_1_b  = op(d + 32'd3, 6'd13, 1'b1);
    return p;
  endfunction

  function automatic writeback_packet_t wb(input logic v, input logic [5:0] t, input logic [31:0] r);
    writeback_packet_t w;
    w.is_valid = v;
    w.dest_reg = t;
    w.result   = r;
    return w;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic disp_n(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      bus.dispatch_packet = rdy_inst(4'h6, base + 32'(k));
      bus.dispatch_valid  = 1'b1;
      step();
    end
    bus.dispatch_valid = 1'b0;
  endtask

  initial begin
    rst                 = 1'b0;
    flush               = 1'b0;
    bus.dispatch_valid  = 1'b0;
    bus.dispatch_packet = '0;
    bus.cdb_packet      = '0;
    bus.alu_rdy         = 1'b0;
    #3;
    chk("reset_dispatch_rdy", 64'(bus.dispatch_rdy), 64'd1);
    chk("reset_count", 64'(bus.rs_count), 64'd0);
    chk("reset_alu_packet", 64'(bus.alu_packet == '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // ready dispatch, then dispatch+issue in the same cycle
    bus.alu_rdy         = 1'b1;
    bus.dispatch_packet = rdy_inst(4'h1, 32'h10);
    bus.dispatch_valid  = 1'b1;
    #1 chk("empty_not_valid", 64'(bus.alu_packet.is_valid), 64'd0);
    step();
    bus.dispatch_packet = rdy_inst(4'h2, 32'h20);
    #1;
    chk("ready_count1", 64'(bus.rs_count), 64'd1);
    chk("ready_issue_valid", 64'(bus.alu_packet.is_valid), 64'd1);
    chk("ready_issue_data", 64'(bus.alu_packet.src_0_a.data), 64'h10);
    step();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("simul_count_hold", 64'(bus.rs_count), 64'd1);
    chk("simul_next_opcode", 64'(bus.alu_packet.opcode), 64'h2);
    step();
    chk("ready_count0", 64'(bus.rs_count), 64'd0);
    chk("ready_drained", 64'(bus.alu_packet.is_valid), 64'd0);

    // wakeup through the CDB
    pkt         = rdy_inst(4'h3, 32'h30);
    pkt.src_0_b = op(32'h0, 6'd5, 1'b0);
    bus.dispatch_packet = pkt;
    bus.dispatch_valid  = 1'b1;
    step();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("wake_count1", 64'(bus.rs_count), 64'd1);
    chk("wake_not_eligible", 64'(bus.alu_packet.is_valid), 64'd0);
    bus.cdb_packet = wb(1'b0, 6'd5, 32'h5555);
    step();
    bus.cdb_packet = '0;
    #1 chk("cdb_invalid_ignored", 64'(bus.alu_packet.is_valid), 64'd0);
    bus.cdb_packet = wb(1'b1, 6'd5, 32'h1234);
    #1 chk("woken_same_cycle", 64'(bus.alu_packet.is_valid), 64'd0);
    step();
    bus.cdb_packet = '0;
    #1;
    chk("wake_issue_valid", 64'(bus.alu_packet.is_valid), 64'd1);
    chk("wake_issue_data", 64'(bus.alu_packet.src_0_b.data), 64'h1234);
    step();
    chk("wake_count0", 64'(bus.rs_count), 64'd0);

    // dispatch bypass; an already-ready slot with the same tag keeps its data
    bus.alu_rdy         = 1'b0;
    pkt                 = rdy_inst(4'h4, 32'h40);
    pkt.src_1_a         = op(32'h0, 6'd7, 1'b0);
    pkt.src_0_a         = op(32'h11, 6'd7, 1'b1);
    bus.dispatch_packet = pkt;
    bus.dispatch_valid  = 1'b1;
    bus.cdb_packet      = wb(1'b1, 6'd7, 32'hDEAD);
    step();
    bus.dispatch_valid = 1'b0;
    bus.cdb_packet     = '0;
    #1;
    chk("bypass_valid", 64'(bus.alu_packet.is_valid), 64'd1);
    chk("bypass_data", 64'(bus.alu_packet.src_1_a.data), 64'hDEAD);
    chk("rdy_slot_ignores", 64'(bus.alu_packet.src_0_a.data), 64'h11);
    bus.alu_rdy = 1'b1;
    step();
    chk("bypass_count0", 64'(bus.rs_count), 64'd0);

    // fill under backpressure
    bus.alu_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.dispatch_packet = rdy_inst(4'h5, 32'(k));
      bus.dispatch_valid  = 1'b1;
      step();
      chk("fill_count", 64'(bus.rs_count), 64'(k + 1));
    end
    chk("full_dispatch_rdy", 64'(bus.dispatch_rdy), 64'd0);
    chk("full_head", 64'(bus.alu_packet.src_0_a.data), 64'd0);
    bus.dispatch_packet = rdy_inst(4'h5, 32'h99);
    step();
    chk("full_ignore_count", 64'(bus.rs_count), 64'd8);
    chk("full_head_stable", 64'(bus.alu_packet.src_0_a.data), 64'd0);
    bus.alu_rdy = 1'b1;
    step();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("full_simul_count", 64'(bus.rs_count), 64'd7);
    for (int k = 1; k < 8; k++) begin
      chk("issue_order", 64'(bus.alu_packet.src_0_a.data), 64'(k));
      step();
    end
    chk("order_count0", 64'(bus.rs_count), 64'd0);
    chk("order_drained", 64'(bus.alu_packet.is_valid), 64'd0);

    // flush with concurrent dispatch
    bus.alu_rdy = 1'b0;
    disp_n(5, 32'h100);
    chk("pre_flush_count", 64'(bus.rs_count), 64'd5);
    flush               = 1'b1;
    bus.dispatch_packet = rdy_inst(4'h7, 32'h200);
    bus.dispatch_valid  = 1'b1;
    bus.alu_rdy         = 1'b1;
    #1 chk("flush_cycle_packet", 64'(bus.alu_packet.src_0_a.data), 64'h100);
    step();
    flush              = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.alu_rdy        = 1'b0;
    #1;
    chk("flush_count", 64'(bus.rs_count), 64'd0);
    chk("flush_no_valid", 64'(bus.alu_packet.is_valid), 64'd0);
    chk("flush_dispatch_rdy", 64'(bus.dispatch_rdy), 64'd1);

    // asynchronous reset mid-cycle
    disp_n(5, 32'h300);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_count", 64'(bus.rs_count), 64'd0);
    chk("rst_async_packet", 64'(bus.alu_packet == '0), 64'd1);
    chk("rst_async_rdy", 64'(bus.dispatch_rdy), 64'd1);
    step();
    @(negedge clk);
    rst                 = 1'b1;
    bus.dispatch_packet = rdy_inst(4'h8, 32'h400);
    bus.dispatch_valid  = 1'b1;
    step();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("post_rst_count", 64'(bus.rs_count), 64'd1);
    chk("post_rst_data", 64'(bus.alu_packet.src_0_a.data), 64'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
